// File: rtl/cva6_sv32_tlb.sv
// Fully-associative Sv32 TLB: combinational VPN/ASID lookup, packed-word fill,
// SFENCE.VMA-style flush, first-invalid else tree pseudo-LRU replacement.
module cva6_sv32_tlb #(
  parameter int unsigned TLB_ENTRIES = 4,
  parameter int unsigned ASID_WIDTH  = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [62:0]                 update_i,
  input  logic                        lu_access_i,
  input  logic [ASID_WIDTH-1:0]       lu_asid_i,
  input  logic [31:0]                 lu_vaddr_i,
  output logic [31:0]                 lu_content_o,
  input  logic [ASID_WIDTH-1:0]       asid_to_be_flushed_i,
  input  logic [31:0]                 vaddr_to_be_flushed_i,
  output logic                        lu_is_4M_o,
  output logic                        lu_hit_o,
  output logic [TLB_ENTRIES*31-1:0]   port_tags_q_o,
  output logic [TLB_ENTRIES*32-1:0]   port_content_q_o,
  output logic [TLB_ENTRIES-1:0]      port_replace_en_o
);

  localparam int unsigned IDX_W    = $clog2(TLB_ENTRIES);
  localparam int unsigned NODE_W   = IDX_W + 1;
  localparam int unsigned PLRU_W   = TLB_ENTRIES - 1;
  localparam int unsigned PAD_W    = 2 * TLB_ENTRIES;
  localparam int unsigned TAG_V    = 0;
  localparam int unsigned TAG_4M   = 1;
  localparam int unsigned ASID_LSB = 22;
  localparam int unsigned PTE_G    = 5;

  logic [30:0]             tags_q    [TLB_ENTRIES];
  logic [31:0]             content_q [TLB_ENTRIES];
  logic [PLRU_W-1:0]       plru_q;
  logic [PLRU_W-1:0]       plru_upd;
  logic [PAD_W-1:0]        plru_pad;
  logic [PAD_W-1:0]        plru_upd_pad;

  logic [TLB_ENTRIES-1:0]  lu_match;
  logic [TLB_ENTRIES-1:0]  fl_vmatch;
  logic [TLB_ENTRIES-1:0]  fl_amatch;
  logic [TLB_ENTRIES-1:0]  fl_clear;
  logic [IDX_W-1:0]        hit_idx;
  logic [IDX_W-1:0]        plru_victim;
  logic [IDX_W-1:0]        repl_idx;
  logic [NODE_W-1:0]       vnode;
  logic [NODE_W-1:0]       unode;
  logic [IDX_W-1:0]        hit_shift;
  logic                    found_invalid;
  logic                    unused_ok;

  // Superpages compare only vpn1; 4 KiB pages compare both halves.
  function automatic logic vpn_match(input logic [30:0] tag, input logic [31:0] vaddr);
    return (tag[21:12] == vaddr[31:22]) && (tag[TAG_4M] || (tag[11:2] == vaddr[21:12]));
  endfunction

  always_comb begin
    lu_match  = '0;
    fl_vmatch = '0;
    fl_amatch = '0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      lu_match[i]  = tags_q[i][TAG_V] && vpn_match(tags_q[i], lu_vaddr_i) &&
                     ((tags_q[i][ASID_LSB +: ASID_WIDTH] == lu_asid_i) || content_q[i][PTE_G]);
      fl_vmatch[i] = vpn_match(tags_q[i], vaddr_to_be_flushed_i);
      fl_amatch[i] = (tags_q[i][ASID_LSB +: ASID_WIDTH] == asid_to_be_flushed_i) &&
                     !content_q[i][PTE_G];
    end
  end

  always_comb begin
    unique case ({|asid_to_be_flushed_i, |vaddr_to_be_flushed_i})
      2'b00:   fl_clear = '1;
      2'b01:   fl_clear = fl_vmatch;
      2'b10:   fl_clear = fl_amatch;
      default: fl_clear = fl_vmatch & fl_amatch;
    endcase
  end

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    lu_hit_o     = 1'b0;
    hit_idx      = '0;
    lu_content_o = '0;
    lu_is_4M_o   = 1'b0;
    for (int unsigned k = 0; k < TLB_ENTRIES; k++) begin
      if (lu_match[TLB_ENTRIES-1-k]) begin
        lu_hit_o     = 1'b1;
        hit_idx      = IDX_W'(TLB_ENTRIES-1-k);
        lu_content_o = content_q[TLB_ENTRIES-1-k];
        lu_is_4M_o   = tags_q[TLB_ENTRIES-1-k][TAG_4M];
      end
    end
  end

  // Tree walk uses heap indices padded so the node index width matches the vector.
  always_comb begin
    plru_pad = {{(PAD_W-PLRU_W){1'b0}}, plru_q};
    vnode    = '0;
    for (int unsigned l = 0; l < IDX_W; l++) begin
      vnode = plru_pad[vnode] ? ({vnode[NODE_W-2:0], 1'b0} + NODE_W'(2))
                              : ({vnode[NODE_W-2:0], 1'b0} + NODE_W'(1));
    end
    plru_victim = IDX_W'(vnode - NODE_W'(PLRU_W));
  end

  always_comb begin
    plru_upd_pad = plru_pad;
    unode        = '0;
    hit_shift    = '0;
    for (int unsigned l = 0; l < IDX_W; l++) begin
      hit_shift           = hit_idx >> (IDX_W - 1 - l);
      plru_upd_pad[unode] = ~hit_shift[0];
      unode               = {unode[NODE_W-2:0], 1'b0} + NODE_W'(1) + NODE_W'(hit_shift[0]);
    end
    plru_upd = plru_upd_pad[PLRU_W-1:0];
  end

  always_comb begin
    found_invalid = 1'b0;
    repl_idx      = plru_victim;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      if (!found_invalid && !tags_q[i][TAG_V]) begin
        found_invalid = 1'b1;
        repl_idx      = IDX_W'(i);
      end
    end
    port_replace_en_o           = '0;
    port_replace_en_o[repl_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
        tags_q[i]    <= '0;
        content_q[i] <= '0;
      end
      plru_q <= '0;
    end else begin
      if (flush_i) begin
        for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
          if (fl_clear[i]) tags_q[i][TAG_V] <= 1'b0;
        end
      end else if (update_i[62]) begin
        tags_q[repl_idx]    <= {update_i[40:32], update_i[60:51], update_i[50:41], update_i[61], 1'b1};
        content_q[repl_idx] <= update_i[31:0];
      end
      if (lu_access_i && lu_hit_o) plru_q <= plru_upd;
    end
  end

  for (genvar g = 0; g < TLB_ENTRIES; g++) begin : g_flat
    assign port_tags_q_o[31*g +: 31]    = tags_q[g];
    assign port_content_q_o[32*g +: 32] = content_q[g];
  end

  assign unused_ok = ^{lu_vaddr_i[11:0], plru_upd_pad[PAD_W-1:PLRU_W]};

endmodule

// File: tb/tb_cva6_sv32_tlb.sv
// Scoreboard bench for cva6_sv32_tlb: fills, lookups, PLRU eviction, flush cases
// and two-instance determinism.
module tb_cva6_sv32_tlb;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [62:0]     upd = '0;
  logic            acc = 1'b0;
  logic [AW-1:0]   lasid = '0;
  logic [31:0]     lva = '0;
  logic [AW-1:0]   fasid = '0;
  logic [31:0]     fva = '0;

  logic [31:0]     cont, cont2;
  logic            is4m, is4m2, hit, hit2;
  logic [N*31-1:0] tags, tags2;
  logic [N*32-1:0] contv, contv2;
  logic [N-1:0]    repl, repl2;

  cva6_sv32_tlb #(.TLB_ENTRIES(N), .ASID_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst), .flush_i(flush), .update_i(upd), .lu_access_i(acc),
    .lu_asid_i(lasid), .lu_vaddr_i(lva), .lu_content_o(cont),
    .asid_to_be_flushed_i(fasid), .vaddr_to_be_flushed_i(fva), .lu_is_4M_o(is4m),
    .lu_hit_o(hit), .port_tags_q_o(tags), .port_content_q_o(contv), .port_replace_en_o(repl)
  );

  cva6_sv32_tlb #(.TLB_ENTRIES(N), .ASID_WIDTH(AW)) dut2 (
    .clk_i(clk), .rst_ni(rst), .flush_i(flush), .update_i(upd), .lu_access_i(acc),
    .lu_asid_i(lasid), .lu_vaddr_i(lva), .lu_content_o(cont2),
    .asid_to_be_flushed_i(fasid), .vaddr_to_be_flushed_i(fva), .lu_is_4M_o(is4m2),
    .lu_hit_o(hit2), .port_tags_q_o(tags2), .port_content_q_o(contv2), .port_replace_en_o(repl2)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {O_HIT, O_CONT, O_4M, O_REPL, O_TAGS, O_CONTV, O_VALID} obs_e;
  typedef struct {
    string        tag;
    obs_e         sel;
    logic [127:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [30:0] et [N];
  logic [31:0] ec [N];

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] observe(input obs_e s);
    logic [127:0] v;
    v = '0;
    case (s)
      O_HIT:   v = 128'(hit);
      O_CONT:  v = 128'(cont);
      O_4M:    v = 128'(is4m);
      O_REPL:  v = 128'(repl);
      O_TAGS:  v = 128'(tags);
      O_CONTV: v = 128'(contv);
      default: for (int i = 0; i < N; i++) v[i] = tags[31*i];
    endcase
    return v;
  endfunction

  function automatic logic [127:0] model_tags();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[31*i +: 31] = et[i];
    return v;
  endfunction

  function automatic logic [127:0] model_contv();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[32*i +: 32] = ec[i];
    return v;
  endfunction

  task automatic push_exp(input string tag, input obs_e sel, input logic [127:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int idx, input logic sp, input logic [19:0] vpn,
                      input logic [8:0] asid, input logic [31:0] pte, input string tag);
    upd = {1'b1, sp, vpn, asid, pte};
    push_exp({tag, "_repl"}, O_REPL, 128'(1) << idx);
    #1;
    drain();
    tick();
    upd = '0;
    et[idx] = {asid, vpn, sp, 1'b1};
    ec[idx] = pte;
    push_exp({tag, "_tags"}, O_TAGS, model_tags());
    push_exp({tag, "_contv"}, O_CONTV, model_contv());
    drain();
  endtask

  task automatic lookup(input string tag, input logic [31:0] va, input logic [AW-1:0] as,
                        input logic eh, input logic [31:0] econt, input logic e4);
    lva   = va;
    lasid = as;
    push_exp({tag, "_hit"}, O_HIT, 128'(eh));
    push_exp({tag, "_cont"}, O_CONT, 128'(econt));
    push_exp({tag, "_4m"}, O_4M, 128'(e4));
    @(negedge clk);
    drain();
  endtask

  task automatic flush_op(input logic [AW-1:0] as, input logic [31:0] va);
    flush = 1'b1;
    fasid = as;
    fva   = va;
    tick();
    flush = 1'b0;
    fasid = '0;
    fva   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      et[i] = '0;
      ec[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    push_exp("rst_hit", O_HIT, '0);
    push_exp("rst_cont", O_CONT, '0);
    push_exp("rst_4m", O_4M, '0);
    push_exp("rst_repl", O_REPL, 128'(1));
    push_exp("rst_tags", O_TAGS, '0);
    push_exp("rst_contv", O_CONTV, '0);
    drain();

    for (int k = 0; k < 4; k++)
      fill(k, 1'b0, 20'(k + 1), 9'h0, (32'(k + 1) << 12) | 32'h1, "fill");
    lookup("lu3", 32'h0000_3000, 1'b0, 1'b1, 32'h0000_3001, 1'b0);
    lookup("lu_off", 32'h0000_1ABC, 1'b0, 1'b1, 32'h0000_1001, 1'b0);
    lookup("lu_miss", 32'h0000_5000, 1'b0, 1'b0, 32'h0, 1'b0);
    push_exp("full_repl", O_REPL, 128'(4'b0001));
    drain();

    // Access entry 0 with PLRU at zero: the tree then points at entry 2.
    lva = 32'h0000_1000; lasid = 1'b0; acc = 1'b1;
    tick();
    acc = 1'b0;
    push_exp("evict_repl", O_REPL, 128'(4'b0100));
    drain();
    fill(2, 1'b0, 20'h00010, 9'h0, 32'h0001_0001, "evict");
    lookup("evicted", 32'h0000_3000, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup("evict_new", 32'h0001_0000, 1'b0, 1'b1, 32'h0001_0001, 1'b0);

    upd = {1'b1, 1'b0, 20'h00055, 9'h0, 32'h0005_5001};
    flush_op('0, 32'h0);
    upd = '0;
    for (int i = 0; i < N; i++) et[i][0] = 1'b0;
    push_exp("fflush_valid", O_VALID, '0);
    push_exp("fflush_tags", O_TAGS, model_tags());
    push_exp("fflush_contv", O_CONTV, model_contv());
    push_exp("fflush_repl", O_REPL, 128'(4'b0001));
    drain();
    lookup("fflush_lu", 32'h0000_1000, 1'b0, 1'b0, 32'h0, 1'b0);

    fill(0, 1'b1, 20'h10000, 9'h0, 32'h1000_000F, "sp");
    lookup("sp_hit", 32'h1003_5000, 1'b0, 1'b1, 32'h1000_000F, 1'b1);
    lookup("sp_top", 32'h103F_FFFF, 1'b0, 1'b1, 32'h1000_000F, 1'b1);
    lookup("sp_out", 32'h1040_0000, 1'b0, 1'b0, 32'h0, 1'b0);

    fill(1, 1'b0, 20'h00020, 9'h1, 32'h0002_0001, "nong");
    fill(2, 1'b0, 20'h00021, 9'h1, 32'h0002_1021, "glob");
    lookup("asid_miss", 32'h0002_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup("asid_hit", 32'h0002_0000, 1'b1, 1'b1, 32'h0002_0001, 1'b0);
    lookup("glob_hit", 32'h0002_1000, 1'b0, 1'b1, 32'h0002_1021, 1'b0);

    flush_op(1'b1, 32'h0);
    et[1][0] = 1'b0;
    push_exp("aflush_valid", O_VALID, 128'(4'b0101));
    push_exp("aflush_tags", O_TAGS, model_tags());
    push_exp("aflush_repl", O_REPL, 128'(4'b0010));
    drain();
    lookup("aflush_nong", 32'h0002_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    lookup("aflush_glob", 32'h0002_1000, 1'b0, 1'b1, 32'h0002_1021, 1'b0);

    flush_op('0, 32'h1000_0000);
    et[0][0] = 1'b0;
    push_exp("vflush_valid", O_VALID, 128'(4'b0100));
    push_exp("vflush_repl", O_REPL, 128'(4'b0001));
    drain();
    lookup("vflush_sp", 32'h1003_5000, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int c = 0; c < 10; c++) begin
      upd   = {1'b1, 62'({$urandom, $urandom})};
      lva   = $urandom;
      lasid = 1'($urandom_range(0, 1));
      acc   = 1'($urandom_range(0, 1));
      tick();
    end
    upd = '0;
    acc = 1'b0;
    chk_eq("twin_contv", 128'(contv), 128'(contv2));
    chk_eq("twin_tags", 128'(tags), 128'(tags2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
